// File: rtl/video_font_pkg.sv
// Character-generator constants, 6x12 glyph table and the code-map
// function shared by the video font ROM.
package video_font_pkg;

    localparam int CH_WIDTH   = 6;
    localparam int CH_HEIGHT  = 12;
    localparam int CODE_W     = 8;
    localparam int GLYPH_BITS = CH_WIDTH * CH_HEIGHT;

    typedef logic [CODE_W-1:0]     code_t;
    typedef logic [GLYPH_BITS-1:0] glyph_t;

    // Entries 0x20..0x7F. Octal pairs are rows 11..0, each row drawn
    // with its MSB as the left pixel; glyph_of mirrors them into place.
    localparam glyph_t GLYPH_TAB [96] = '{
        72'o000000_000000_000000_000000,
        72'o000000_100000_101010_100000,
        72'o000000_000000_002424_240000,
        72'o000000_242476_247624_240000,
        72'o000000_107412_345036_100000,
        72'o000000_064620_100462_600000,
        72'o000000_324452_205044_300000,
        72'o000000_000000_002010_300000,
        72'o000000_041020_202010_040000,
        72'o000000_201004_040410_200000,
        72'o000000_001052_345210_000000,
        72'o000000_001010_761010_000000,
        72'o000000_201030_000000_000000,
        72'o000000_000000_760000_000000,
        72'o000000_303000_000000_000000,
        72'o000000_004020_100402_000000,
        72'o000000_344262_524642_340000,
        72'o000000_341010_101030_100000,
        72'o000000_762010_040242_340000,
        72'o000000_344202_041004_760000,
        72'o000000_040476_442414_040000,
        72'o000000_344202_027440_760000,
        72'o000000_344242_744020_140000,
        72'o000000_202020_100402_760000,
        72'o000000_344242_344242_340000,
        72'o000000_300402_364242_340000,
        72'o000000_003030_003030_000000,
        72'o000000_201030_003030_000000,
        72'o000000_041020_402010_040000,
        72'o000000_000076_007600_000000,
        72'o000000_201004_020410_200000,
        72'o000000_100010_040242_340000,
        72'o000000_345252_320242_340000,
        72'o000000_414141_774141_221400,
        72'o000000_744242_744242_740000,
        72'o000000_344240_404042_340000,
        72'o000000_704442_424244_700000,
        72'o000000_764040_744040_760000,
        72'o000000_404040_744040_760000,
        72'o000000_364242_564042_340000,
        72'o000000_424242_764242_420000,
        72'o000000_341010_101010_340000,
        72'o000000_304404_040404_160000,
        72'o000000_424450_605044_420000,
        72'o000000_764040_404040_400000,
        72'o000000_424242_525266_420000,
        72'o000000_424246_526242_420000,
        72'o000000_344242_424242_340000,
        72'o000000_404040_744242_740000,
        72'o000000_324452_424242_340000,
        72'o000000_424450_744242_740000,
        72'o000000_740202_344040_360000,
        72'o000000_101010_101010_760000,
        72'o000000_344242_424242_420000,
        72'o000000_102442_424242_420000,
        72'o000000_245252_524242_420000,
        72'o000000_424224_102442_420000,
        72'o000000_101010_244242_420000,
        72'o000000_764020_100402_760000,
        72'o000000_342020_202020_340000,
        72'o000000_000204_102040_000000,
        72'o000000_340404_040404_340000,
        72'o000000_000000_004224_100000,
        72'o000000_760000_000000_000000,
        72'o000000_000000_000410_200000,
        72'o000000_364236_023400_000000,
        72'o000000_744242_625440_400000,
        72'o000000_344240_403400_000000,
        72'o000000_364242_463202_020000,
        72'o000000_344076_423400_000000,
        72'o000000_202020_702022_140000,
        72'o003402_364242_423600_000000,
        72'o000000_424242_625440_400000,
        72'o000000_341010_103000_100000,
        72'o003044_040404_041400_040000,
        72'o000000_445060_504440_400000,
        72'o000000_341010_101010_300000,
        72'o000000_424252_526400_000000,
        72'o000000_424242_625400_000000,
        72'o000000_344242_423400_000000,
        72'o004040_744242_427400_000000,
        72'o000202_364242_423600_000000,
        72'o000000_404040_625400_000000,
        72'o000000_740234_403400_000000,
        72'o000000_142220_207020_200000,
        72'o000000_324642_424200_000000,
        72'o000000_102442_424200_000000,
        72'o000000_245252_424200_000000,
        72'o000000_422410_244200_000000,
        72'o003402_364242_424200_000000,
        72'o000000_762010_047600_000000,
        72'o000000_041010_201010_040000,
        72'o000000_101010_101010_100000,
        72'o000000_201010_041010_200000,
        72'o000000_000004_522000_000000,
        72'o777777_777777_777777_777777
    };

    function automatic glyph_t mirror_rows(input glyph_t g);
        glyph_t m;
        m = '0;
        for (int r = 0; r < CH_HEIGHT; r++) begin
            for (int c = 0; c < CH_WIDTH; c++) begin
                m[r*CH_WIDTH + c] = g[r*CH_WIDTH + CH_WIDTH - 1 - c];
            end
        end
        return m;
    endfunction

    function automatic glyph_t glyph_of(input code_t code);
        glyph_t     g;
        logic [6:0] idx;
        g   = '0;
        idx = code[6:0] - 7'h20;
        if (code[6:0] >= 7'h20) begin
            g = mirror_rows(GLYPH_TAB[idx]);
        end
        if (code[7]) begin
            g = ~g;
        end
        return g;
    endfunction

endpackage

// File: rtl/video_font_rom_if.sv
// Code-in / bitmap-out bundle between the video memory and the
// pixel stage.
interface video_font_rom_if;

    video_font_pkg::code_t  ch_code;
    video_font_pkg::glyph_t ch_gfx;

    modport master (
        output ch_code,
        input  ch_gfx
    );

    modport slave (
        input  ch_code,
        output ch_gfx
    );

endinterface

// File: rtl/video_font_lookup.sv
// Combinational character code to glyph bitmap lookup.
module video_font_lookup
    import video_font_pkg::*;
(
    input  code_t  code,
    output glyph_t gfx
);

    assign gfx = glyph_of(code);

endmodule

// File: rtl/video_font_rom.sv
// Character-generator ROM: one-cycle registered glyph lookup with
// asynchronous blanking reset.
module video_font_rom
    import video_font_pkg::*;
(
    input logic           clk,
    input logic           rst_n,
    video_font_rom_if.slave bus
);

    glyph_t gfx_next;

    video_font_lookup u_lookup (
        .code (bus.ch_code),
        .gfx  (gfx_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ch_gfx <= '0;
        end else begin
            bus.ch_gfx <= gfx_next;
        end
    end

endmodule

// File: tb/tb_video_font_rom.sv
// Bench for video_font_rom: reset, code map, latency, sweep,
// random stream and asynchronous reset.
module tb_video_font_rom;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    localparam logic [71:0] ONES = '1;
    localparam logic [71:0] ZERO = '0;

    logic [71:0] a_ref;
    logic [71:0] obs [256];

    video_font_rom_if bus ();

    video_font_rom dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [71:0] build_a();
        string rows [12];
        logic [71:0] g;
        rows = '{"......", "..##..", ".#..#.", "#....#",
                 "#....#", "######", "#....#", "#....#",
                 "#....#", "......", "......", "......"};
        g = '0;
        for (int r = 0; r < 12; r++) begin
            for (int c = 0; c < 6; c++) begin
                g[r*6 + c] = (rows[r][c] == 8'h23);
            end
        end
        return g;
    endfunction

    // Returns 1 when the exact bitmap for c is known from the code map.
    function automatic logic ref_known(input logic [7:0] c,
                                       output logic [71:0] e);
        logic [6:0]  b;
        logic [71:0] g;
        logic        k;
        b = c[6:0];
        g = '0;
        k = 1'b1;
        if (b <= 7'h20) g = '0;
        else if (b == 7'h7F) g = '1;
        else if (b == 7'h41) g = a_ref;
        else k = 1'b0;
        e = c[7] ? ~g : g;
        return k;
    endfunction

    function automatic logic is_desc(input logic [6:0] b);
        return b == 7'h67 || b == 7'h6A || b == 7'h70 ||
               b == 7'h71 || b == 7'h79;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.ch_code = 8'h41;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (bus.ch_gfx !== ZERO) begin
                bad++;
                $display("FAIL reset_hold: got %h want %h", bus.ch_gfx, ZERO);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.ch_gfx !== a_ref) begin
            bad++;
            $display("FAIL reset_release_A: got %h want %h", bus.ch_gfx, a_ref);
        end
        total++;
        if (bus.ch_gfx[9:8] !== 2'b11 || bus.ch_gfx[0] !== 1'b0) begin
            bad++;
            $display("FAIL A_bits: got b9b8=%b b0=%b want 11 0",
                     bus.ch_gfx[9:8], bus.ch_gfx[0]);
        end
        total++;
        if (bus.ch_gfx[71:54] !== 18'h0) begin
            bad++;
            $display("FAIL A_rows9_11: got %h want 0", bus.ch_gfx[71:54]);
        end
    endtask

    task automatic test_specials();
        logic [7:0]  codes [4];
        logic [71:0] exp [4];
        codes = '{8'h20, 8'h7F, 8'hA0, 8'hFF};
        exp   = '{ZERO, ONES, ONES, ZERO};
        bus.ch_code = codes[0];
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            total++;
            if (bus.ch_gfx !== exp[i-1]) begin
                bad++;
                $display("FAIL special_%h: got %h want %h",
                         codes[i-1], bus.ch_gfx, exp[i-1]);
            end
            if (i < 4) bus.ch_code = codes[i];
        end
    endtask

    task automatic test_blank_inverse();
        logic [7:0]  codes [4];
        logic [71:0] exp [4];
        codes = '{8'h05, 8'h1F, 8'h85, 8'hC1};
        exp   = '{ZERO, ZERO, ONES, ~a_ref};
        bus.ch_code = codes[0];
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            total++;
            if (bus.ch_gfx !== exp[i-1]) begin
                bad++;
                $display("FAIL code_%h: got %h want %h",
                         codes[i-1], bus.ch_gfx, exp[i-1]);
            end
            if (i < 4) bus.ch_code = codes[i];
        end
        total++;
        if (bus.ch_gfx[0] !== 1'b1 || bus.ch_gfx[8] !== 1'b0 ||
            bus.ch_gfx[71] !== 1'b1) begin
            bad++;
            $display("FAIL inv_A_bits: got b0=%b b8=%b b71=%b want 1 0 1",
                     bus.ch_gfx[0], bus.ch_gfx[8], bus.ch_gfx[71]);
        end
    endtask

    task automatic test_sweep();
        logic [71:0] e;
        logic [71:0] o;
        logic [71:0] base;
        logic [7:0]  c;
        for (int k = 0; k <= 256; k++) begin
            if (k < 256) bus.ch_code = 8'(k);
            @(negedge clk);
            if (k < 256) begin
                c = 8'(k);
                o = bus.ch_gfx;
                obs[k] = o;
                total++;
                if ($isunknown(o)) begin
                    bad++;
                    $display("FAIL sweep_x_%h: got %h want no X", c, o);
                end else if (ref_known(c, e)) begin
                    if (o !== e) begin
                        bad++;
                        $display("FAIL sweep_%h: got %h want %h", c, o, e);
                    end
                end else begin
                    base = c[7] ? ~o : o;
                    if (base == ZERO ||
                        (!is_desc(c[6:0]) && base[71:54] != 18'h0)) begin
                        bad++;
                        $display("FAIL sweep_shape_%h: got %h want lit rows 0-8",
                                 c, o);
                    end
                end
            end
            if (k < 255) bus.ch_code = 8'(k + 1);
        end
        for (int k = 0; k < 128; k++) begin
            total++;
            if ((obs[k] ^ obs[k | 128]) !== ONES) begin
                bad++;
                $display("FAIL inverse_pair_%h: got %h want %h",
                         k[7:0], obs[k] ^ obs[k | 128], ONES);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0]  prev;
        logic [7:0]  cur;
        logic [71:0] e;
        logic [71:0] o;
        logic [71:0] base;
        prev = 8'($urandom_range(0, 255));
        bus.ch_code = prev;
        for (int i = 0; i < 300; i++) begin
            cur = 8'($urandom_range(0, 255));
            if (i % 4 == 0) cur = {cur[7], 7'h41};
            @(negedge clk);
            o = bus.ch_gfx;
            total++;
            if (ref_known(prev, e)) begin
                if (o !== e) begin
                    bad++;
                    $display("FAIL rand_%h: got %h want %h", prev, o, e);
                end
            end else begin
                base = prev[7] ? ~o : o;
                if ($isunknown(o) || base == ZERO ||
                    (!is_desc(prev[6:0]) && base[71:54] != 18'h0)) begin
                    bad++;
                    $display("FAIL rand_shape_%h: got %h want lit rows 0-8",
                             prev, o);
                end
            end
            bus.ch_code = cur;
            prev = cur;
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        bus.ch_code = 8'h7F;
        @(negedge clk);
        total++;
        if (bus.ch_gfx !== ONES) begin
            bad++;
            $display("FAIL stream_7F: got %h want %h", bus.ch_gfx, ONES);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bus.ch_gfx !== ZERO) begin
            bad++;
            $display("FAIL async_clear: got %h want %h", bus.ch_gfx, ZERO);
        end
        @(negedge clk);
        total++;
        if (bus.ch_gfx !== ZERO) begin
            bad++;
            $display("FAIL reset_held: got %h want %h", bus.ch_gfx, ZERO);
        end
        bus.ch_code = 8'h41;
        rst_n = 1'b1;
        #1;
        total++;
        if (bus.ch_gfx !== ZERO) begin
            bad++;
            $display("FAIL no_early_load: got %h want %h", bus.ch_gfx, ZERO);
        end
        @(negedge clk);
        total++;
        if (bus.ch_gfx !== a_ref) begin
            bad++;
            $display("FAIL resume_A: got %h want %h", bus.ch_gfx, a_ref);
        end
        bus.ch_code = 8'hC1;
        @(negedge clk);
        total++;
        if (bus.ch_gfx !== ~a_ref) begin
            bad++;
            $display("FAIL resume_C1: got %h want %h", bus.ch_gfx, ~a_ref);
        end
    endtask

    initial begin
        a_ref = build_a();
        bus.ch_code = 8'h00;
        test_reset();
        test_specials();
        test_blank_inverse();
        test_sweep();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
